// File: rtl/atan_poly_prog.sv
// Programmable polynomial evaluator: pipelined Horner with one multiply-add per stage,
// optional odd symmetry, and a drain-then-load commit of the coefficient bank.
module atan_poly_prog #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 14,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16,
  parameter int ORDER     = 3,
  parameter int ODD_SYM   = 1,
  localparam int CA_W     = (ORDER > 0) ? $clog2(ORDER + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              val_i,
  output logic              rdy_o,
  input  logic [IN_W-1:0]   atan_poly_i,
  output logic              val_o,
  input  logic              rdy_i,
  output logic [OUT_W-1:0]  atan_poly_o,
  input  logic              coef_we,
  input  logic [CA_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              coef_commit,
  output logic              busy
);

  localparam int ACC_W  = COEF_W + 2;
  localparam int PROD_W = ACC_W + IN_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = COEF_FRAC - OUT_FRAC;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_e;

  function automatic logic signed [ACC_W-1:0] horner_step(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [IN_W-1:0]   x,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic signed [SUM_W-1:0]  sum;
    prod   = $signed({{IN_W{acc[ACC_W-1]}}, acc}) * $signed({{ACC_W{x[IN_W-1]}}, x});
    scaled = prod >>> (IN_W - 1);
    sum    = $signed({scaled[PROD_W-1], scaled}) +
             $signed({{(SUM_W-COEF_W){c[COEF_W-1]}}, c});
    if (sum[SUM_W-1:ACC_W-1] == {(SUM_W-ACC_W+1){sum[SUM_W-1]}}) begin
      horner_step = sum[ACC_W-1:0];
    end else if (sum[SUM_W-1]) begin
      horner_step = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      horner_step = {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction

  // Rescale to the output format, then fold the sign back in (most negative maps to max).
  function automatic logic signed [OUT_W-1:0] out_stage(
    input logic signed [ACC_W-1:0] acc,
    input logic                    neg
  );
    logic signed [ACC_W-1:0] sh;
    logic signed [OUT_W-1:0] y;
    sh = acc >>> SHIFT;
    if (sh[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){sh[ACC_W-1]}}) begin
      y = sh[OUT_W-1:0];
    end else if (sh[ACC_W-1]) begin
      y = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y = {1'b0, {(OUT_W-1){1'b1}}};
    end
    if (!neg) begin
      out_stage = y;
    end else if (y == {1'b1, {(OUT_W-1){1'b0}}}) begin
      out_stage = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      out_stage = -y;
    end
  endfunction

  logic                     en_s, accept_s, any_valid_s, neg_s;
  logic signed [IN_W-1:0]   xabs_s;
  logic                     v_q   [0:ORDER];
  logic                     neg_q [0:ORDER];
  logic signed [IN_W-1:0]   x_q   [0:ORDER-1];
  logic signed [ACC_W-1:0]  acc_q [0:ORDER-1];
  logic signed [ACC_W-1:0]  acc_d [0:ORDER-1];
  logic signed [ACC_W-1:0]  acc_in_s [0:ORDER-1];
  logic signed [COEF_W-1:0] shadow_q [0:ORDER];
  logic signed [COEF_W-1:0] active_q [0:ORDER];
  logic                     val_q, busy_q;
  logic signed [OUT_W-1:0]  y_q;
  state_e                   state_q;

  assign en_s        = rdy_i | ~val_q;
  assign rdy_o       = en_s & (state_q == RUN);
  assign accept_s    = val_i & rdy_o;
  assign val_o       = val_q;
  assign atan_poly_o = y_q;
  assign busy        = busy_q;

  always_comb begin
    neg_s  = 1'b0;
    xabs_s = atan_poly_i;
    if ((ODD_SYM != 0) && atan_poly_i[IN_W-1]) begin
      neg_s = 1'b1;
      if (atan_poly_i == {1'b1, {(IN_W-1){1'b0}}}) begin
        xabs_s = {1'b0, {(IN_W-1){1'b1}}};
      end else begin
        xabs_s = -atan_poly_i;
      end
    end else begin
      neg_s  = 1'b0;
      xabs_s = atan_poly_i;
    end
  end

  // Horner stage j consumes coefficient c[ORDER-1-j]; stage 0 starts from c[ORDER].
  always_comb begin
    acc_in_s[0] = $signed({{(ACC_W-COEF_W){active_q[ORDER][COEF_W-1]}}, active_q[ORDER]});
    for (int j = 1; j < ORDER; j++) begin
      acc_in_s[j] = acc_q[j-1];
    end
    for (int j = 0; j < ORDER; j++) begin
      acc_d[j] = horner_step(acc_in_s[j], x_q[j], active_q[ORDER-1-j]);
    end
  end

  always_comb begin
    any_valid_s = val_q;
    for (int j = 0; j <= ORDER; j++) begin
      any_valid_s = any_valid_s | v_q[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= ORDER; j++) begin
        v_q[j]   <= 1'b0;
        neg_q[j] <= 1'b0;
      end
      for (int j = 0; j < ORDER; j++) begin
        x_q[j]   <= '0;
        acc_q[j] <= '0;
      end
      val_q <= 1'b0;
      y_q   <= '0;
    end else if (en_s) begin
      v_q[0]   <= accept_s;
      neg_q[0] <= neg_s;
      x_q[0]   <= xabs_s;
      for (int j = 0; j < ORDER; j++) begin
        v_q[j+1]   <= v_q[j];
        neg_q[j+1] <= neg_q[j];
        acc_q[j]   <= acc_d[j];
      end
      for (int j = 0; j < ORDER - 1; j++) begin
        x_q[j+1] <= x_q[j];
      end
      val_q <= v_q[ORDER];
      if (v_q[ORDER]) begin
        y_q <= out_stage(acc_q[ORDER-1], neg_q[ORDER]);
      end
    end
  end

  // Active bank only changes in LOAD, when no sample is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      busy_q  <= 1'b0;
      for (int k = 0; k <= ORDER; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (coef_we && (int'(coef_addr) <= ORDER)) begin
        shadow_q[coef_addr] <= coef_wdata;
      end
      case (state_q)
        RUN: begin
          if (coef_commit) begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!any_valid_s) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          for (int k = 0; k <= ORDER; k++) begin
            active_q[k] <= shadow_q[k];
          end
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atan_poly_prog.sv
// Directed bench for atan_poly_prog with hand-computed expected results.
module tb_atan_poly_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        val_i, rdy_o, val_o, rdy_i;
  logic [7:0]  atan_poly_i;
  logic [15:0] atan_poly_o;
  logic        coef_we, coef_commit, busy;
  logic [1:0]  coef_addr;
  logic [17:0] coef_wdata;

  int checks   = 0;
  int failures = 0;

  atan_poly_prog #(
    .IN_W(8), .OUT_W(16), .OUT_FRAC(14), .COEF_W(18), .COEF_FRAC(16), .ORDER(3), .ODD_SYM(1)
  ) dut (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o), .atan_poly_i(atan_poly_i),
    .val_o(val_o), .rdy_i(rdy_i), .atan_poly_o(atan_poly_o), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input int k, input int v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 2'(k);
    coef_wdata = 18'(v);
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  task automatic do_commit();
    int n;
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    #1;
    check("busy_set", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_clr", 32'(busy), 32'd0);
  endtask

  // One isolated sample: checks acceptance, 5-cycle latency and the value.
  task automatic run_one(input string tag, input logic [7:0] x, input logic [15:0] exp);
    int n;
    @(negedge clk);
    val_i       = 1'b1;
    atan_poly_i = x;
    #1;
    check({tag, "_rdy"}, 32'(rdy_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    val_i = 1'b0;
    n = 1;
    while (!val_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd5);
    check(tag, 32'(atan_poly_o), 32'(exp));
  endtask

  logic [7:0]  xs5   [0:7];
  logic [15:0] exp5  [0:7];
  logic [15:0] recv5 [0:7];
  logic [15:0] exp6  [0:63];
  logic [15:0] recv6 [0:63];

  initial begin
    int sent, nrecv, nacc, busy_cnt, first_after;
    logic hold_pend;
    logic [15:0] hold_val;

    rst = 1'b1; val_i = 1'b0; rdy_i = 1'b1; atan_poly_i = 8'h00;
    coef_we = 1'b0; coef_addr = 2'd0; coef_wdata = 18'd0; coef_commit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_val_o", 32'(val_o), 32'd0);
    check("rst_data", 32'(atan_poly_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rdy", 32'(rdy_o), 32'd1);

    // Zero coefficients after reset
    run_one("zero_coef", 8'h40, 16'h0000);
    check("t1_busy", 32'(busy), 32'd0);

    // Identity polynomial y = x
    write_coef(1, 65536);
    do_commit();
    run_one("ident_40", 8'h40, 16'h2000);
    run_one("ident_00", 8'h00, 16'h0000);
    run_one("odd_C0", 8'hC0, 16'hE000);
    run_one("odd_80", 8'h80, 16'hC080);

    // Saturation of the output stage
    write_coef(0, 131071);
    write_coef(1, 131071);
    do_commit();
    run_one("sat_pos", 8'h7F, 16'h7FFF);
    run_one("sat_neg", 8'h81, 16'h8001);

    // Back to identity, then stream with a 3-cycle downstream stall
    write_coef(0, 0);
    write_coef(1, 65536);
    do_commit();
    for (int i = 0; i < 8; i++) begin
      xs5[i]  = ((i % 2) == 0) ? 8'(8 * (i + 1)) : 8'(-8 * (i + 1));
      exp5[i] = ((i % 2) == 0) ? 16'(1024 * (i + 1)) : 16'(-1024 * (i + 1));
    end
    sent = 0; nrecv = 0; hold_pend = 1'b0; hold_val = 16'h0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdy_i       = !(c >= 6 && c <= 8);
      val_i       = (sent < 8);
      atan_poly_i = (sent < 8) ? xs5[sent] : 8'h00;
      #1;
      if (hold_pend) begin
        check("hold_val", 32'(val_o), 32'd1);
        check("hold_data", 32'(atan_poly_o), 32'(hold_val));
      end
      if (!rdy_i) check("stall_rdy", 32'(rdy_o), 32'd0);
      if (val_o && rdy_i) begin
        if (nrecv < 8) recv5[nrecv] = atan_poly_o;
        nrecv++;
      end
      hold_pend = val_o && !rdy_i;
      hold_val  = atan_poly_o;
      if (val_i && rdy_o) sent++;
    end
    val_i = 1'b0;
    rdy_i = 1'b1;
    check("bp_count", 32'(nrecv), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < nrecv) check($sformatf("bp_res%0d", i), 32'(recv5[i]), 32'(exp5[i]));
    end

    // Commit during a continuous stream: c1 halves the gain after resume
    nacc = 0; nrecv = 0; busy_cnt = 0; first_after = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      val_i       = (c < 25);
      atan_poly_i = 8'h40;
      coef_we     = (c == 4);
      coef_addr   = 2'd1;
      coef_wdata  = 18'd32768;
      coef_commit = (c == 4);
      #1;
      if (busy) begin
        busy_cnt++;
        check("drain_rdy", 32'(rdy_o), 32'd0);
      end
      if (val_o) begin
        if (nrecv < 64) recv6[nrecv] = atan_poly_o;
        nrecv++;
      end
      if (val_i && rdy_o) begin
        if (nacc < 64) exp6[nacc] = (c <= 4) ? 16'd8192 : 16'd4096;
        nacc++;
        if (c > 4 && first_after < 0) first_after = c;
      end
    end
    val_i = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'd7);
    check("resume_cycle", 32'(first_after), 32'd12);
    check("cm_accepted", 32'(nacc), 32'd18);
    check("cm_count", 32'(nrecv), 32'(nacc));
    for (int i = 0; i < 64; i++) begin
      if (i < nacc && i < nrecv) check($sformatf("cm_res%0d", i), 32'(recv6[i]), 32'(exp6[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/atan_poly_prog.md
Name: atan_poly_prog

Overview:
- Parametrised, programmable successor to the fixed 8-in/16-out arctangent polynomial unit.
- Evaluates a runtime-loadable polynomial of order ORDER by pipelined Horner, one stage per step.
- Optional odd-symmetry mode for atan.
- Valid/ready streaming with backpressure; sits between angle-ratio datapath and downstream phase logic.

Parameters:
- IN_W, 8: input width; signed Q1.(IN_W-1).
- OUT_W, 16: output width; signed, OUT_FRAC fractional bits.
- OUT_FRAC, 14: output fractional bits; must be <= COEF_FRAC.
- COEF_W, 18: coefficient width; signed, COEF_FRAC fractional bits.
- COEF_FRAC, 16: coefficient and accumulator fractional bits.
- ORDER, 3: polynomial order; ORDER+1 coefficients c0..cORDER.
- ODD_SYM, 1: 1 = evaluate on |x| and negate the result for x<0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- val_i  in  1  input sample valid.
- rdy_o  out  1  block can accept a sample.
- atan_poly_i  in  IN_W  input sample x.
- val_o  out  1  output valid.
- rdy_i  in  1  downstream ready.
- atan_poly_o  out  OUT_W  result y.
- coef_we  in  1  write coef_wdata into shadow bank.
- coef_addr  in  clog2(ORDER+1)  coefficient index k.
- coef_wdata  in  COEF_W  coefficient value.
- coef_commit  in  1  request shadow-to-active copy (pulse).
- busy  out  1  commit pending (DRAIN or LOAD).

Behaviour:
- Reset (async, active-high):
  - val_o=0, atan_poly_o=0, busy=0; rdy_o=1 once reset deasserts.
  - All pipeline valid bits cleared.
  - Shadow and active coefficients reset to 0.
- Pipeline enable: en = rdy_i | ~val_o. All stages advance only when en=1; bubbles are not collapsed.
- Acceptance: rdy_o = en & (state==RUN). A sample is accepted when val_i & rdy_o.
- Latency: exactly ORDER+2 enabled cycles from acceptance to val_o.
  - Stage S0 (input register): if ODD_SYM, x' = |x|; x = -2^(IN_W-1) saturates to 2^(IN_W-1)-1. Sign of x is carried along. If ODD_SYM=0, x' = x.
  - Stages S1..SORDER (Horner):
    - acc starts at sign-extended cORDER.
    - Each stage: acc = sat_ACC(floor((acc*x') / 2^(IN_W-1)) + c_k), k descending ORDER-1..0.
    - ACC_W = COEF_W+2. The product is full width; the shift is arithmetic; sat_ACC clamps to the signed ACC_W range.
  - Output stage:
    - y = sat_OUT(acc >>> (COEF_FRAC-OUT_FRAC)), arithmetic shift.
    - If ODD_SYM and x<0: y = sat_OUT(-y); -2^(OUT_W-1) maps to 2^(OUT_W-1)-1.
- Output hold: while val_o=1 and rdy_i=0, atan_poly_o and val_o are held stable.
- Coefficient writes:
  - coef_we writes the shadow bank at any time, including during a commit.
  - coef_addr > ORDER is ignored.
- Commit FSM:
  - RUN: on coef_commit, go to DRAIN; busy=1; rdy_o=0 from the next cycle. The sample accepted in the commit cycle still uses the old coefficients.
  - DRAIN: stay until all stage valid bits and val_o are 0, then go to LOAD.
  - LOAD: one cycle; active <= shadow; go to RUN; busy=0.
  - Write and commit in the same cycle: the written value is included in the commit.
  - coef_commit while in DRAIN or LOAD is ignored.
  - Rule: no sample ever sees a mix of old and new coefficients.
- Reset mid-operation: all in-flight samples are discarded and the FSM returns to RUN.

Test Plan (IN_W=8, OUT_W=16, OUT_FRAC=14, COEF_W=18, COEF_FRAC=16, ORDER=3):
1. Reset, then val_i=1 with x=0x40 before any commit -> rdy_o=1; result 0x0000 exactly 5 cycles after acceptance; busy=0.
2. Identity: c1=65536, other coefficients 0, commit, then x=0x40 -> atan_poly_o=8192 (0x2000) 5 cycles after acceptance; x=0x00 -> 0.
3. Odd symmetry, identity coefficients:
   - x=0xC0 -> 0xE000 (-8192).
   - x=0x80 -> |x|=127 -> -16256 (0xC080).
4. Saturation: c0=c1=131071, c2=c3=0, x=0x7F -> acc=261118 -> 65279 clamped -> 0x7FFF; x=0x81 (odd mode) -> 0x8001.
5. Backpressure: stream 8 samples, hold rdy_i=0 for 3 cycles mid-stream -> rdy_o=0 during the stall; val_o/atan_poly_o held; all 8 results arrive in order, none lost or duplicated.
6. Commit mid-stream: identity coefficients active, stream x=0x40; write c1=32768 and pulse commit -> busy=1, rdy_o=0 until drained, one LOAD cycle. Pre-commit samples give 8192; samples after resume give 4096.
